// File: rtl/oled_link_scheduler.sv
// ---------------------------------------------------------------------------
// oled_link_scheduler
//
// Sequences the byte stream sent to an SSD1306-style OLED over an SPI
// serializer. Each frame is: pending runtime commands (dc=0), a fixed
// column/page address window (dc=0), then PIXEL_BYTES pattern bytes (dc=1),
// then FRAME_WAIT idle cycles before the next frame.
//
// Parameters
//   FRAME_WAIT   idle cycles between frames (>= 1)
//   CMD_DEPTH    runtime command FIFO depth (power of two, 2..16)
//   PIXEL_BYTES  data bytes per frame (<= 1024)
//
// Ports
//   clk           system clock, posedge
//   rst_n         asynchronous active-low reset
//   enable        display init complete; sampled in IDLE and at end of WAIT
//   frame_clr     one-cycle pulse, clears frame_number
//   cmd_valid     runtime command push strobe
//   cmd_data      runtime command byte
//   cmd_ready     command FIFO not full
//   pixel_index   byte address to the pattern generator
//   pattern_byte  generator output for pixel_index
//   tx_valid      byte offered to the serializer
//   tx_data       byte value
//   tx_dc         0 = command, 1 = data
//   tx_ready      serializer accepts when tx_valid & tx_ready
//   frame_number  completed-frame count (wraps)
//   frame_done    one-cycle pulse after the last data byte is accepted
//   busy          high outside IDLE and WAIT
// ---------------------------------------------------------------------------
module oled_link_scheduler #(
   parameter logic [31:0] FRAME_WAIT  = 32'd450000,
   parameter int          CMD_DEPTH   = 4,
   parameter int          PIXEL_BYTES = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       frame_clr,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   output logic [9:0] pixel_index,
   input  logic [7:0] pattern_byte,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   output logic       tx_dc,
   input  logic       tx_ready,
   output logic [7:0] frame_number,
   output logic       frame_done,
   output logic       busy
);

   localparam int               PTR_W       = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int               CNT_W       = PTR_W + 1;
   localparam logic [CNT_W-1:0] LP_FULL     = CNT_W'(CMD_DEPTH);
   localparam logic [9:0]       LP_LAST_PIX = 10'(PIXEL_BYTES - 1);
   localparam logic [31:0]      LP_WAIT_TC  = FRAME_WAIT - 32'd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_FETCH,
      S_DATA,
      S_WAIT
   } state_t;

   state_t           r_state;
   logic [7:0]       r_fifo [CMD_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [2:0]       r_addr_idx;
   logic [9:0]       r_pixel_index;
   logic             r_tx_valid;
   logic [7:0]       r_tx_data;
   logic             r_tx_dc;
   logic [7:0]       r_frame_number;
   logic             r_frame_done;
   logic             r_busy;
   logic [31:0]      r_wait_cnt;

   logic             w_push;
   logic             w_pop;
   logic             w_tx_free;
   logic             w_last_accept;

   // Address window: columns 0..127, pages 0..7.
   function automatic logic [7:0] f_addr_byte(input logic [2:0] idx);
      case (idx)
         3'd0:    f_addr_byte = 8'h21;
         3'd1:    f_addr_byte = 8'h00;
         3'd2:    f_addr_byte = 8'h7F;
         3'd3:    f_addr_byte = 8'h22;
         3'd4:    f_addr_byte = 8'h00;
         3'd5:    f_addr_byte = 8'h07;
         default: f_addr_byte = 8'h00;
      endcase
   endfunction

   assign cmd_ready = (r_count != LP_FULL);
   assign w_push    = cmd_valid && cmd_ready;

   // Output slot can take a new byte when empty or being accepted this cycle.
   assign w_tx_free = !r_tx_valid || tx_ready;

   // Commands are only drained in CMD, so pushes during a frame wait their turn.
   assign w_pop = (r_state == S_CMD) && w_tx_free && (r_count != '0);

   assign w_last_accept = (r_state == S_DATA) && tx_ready && (r_pixel_index == LP_LAST_PIX);

   // Command FIFO storage (data only, no reset needed).
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= cmd_data;
      end
   end

   // Command FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Frame sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_addr_idx     <= 3'd0;
         r_pixel_index  <= 10'd0;
         r_tx_valid     <= 1'b0;
         r_tx_data      <= 8'h00;
         r_tx_dc        <= 1'b0;
         r_frame_number <= 8'h00;
         r_frame_done   <= 1'b0;
         r_busy         <= 1'b0;
         r_wait_cnt     <= 32'd0;
      end else begin
         r_frame_done <= 1'b0;

         // A clear in the same cycle as the last data acceptance wins.
         if (frame_clr) begin
            r_frame_number <= 8'h00;
         end else if (w_last_accept) begin
            r_frame_number <= r_frame_number + 8'd1;
         end

         case (r_state)
            S_IDLE: begin
               if (enable) begin
                  r_state <= S_CMD;
                  r_busy  <= 1'b1;
               end
            end

            S_CMD: begin
               if (w_tx_free) begin
                  if (w_pop) begin
                     r_tx_valid <= 1'b1;
                     r_tx_data  <= r_fifo[r_rd_ptr];
                     r_tx_dc    <= 1'b0;
                  end else begin
                     r_tx_valid <= 1'b0;
                     r_addr_idx <= 3'd0;
                     r_state    <= S_ADDR;
                  end
               end
            end

            S_ADDR: begin
               if (w_tx_free) begin
                  if (r_addr_idx != 3'd6) begin
                     r_tx_valid <= 1'b1;
                     r_tx_data  <= f_addr_byte(r_addr_idx);
                     r_tx_dc    <= 1'b0;
                     r_addr_idx <= r_addr_idx + 3'd1;
                  end else begin
                     // Last address byte accepted: start pixel stream at 0.
                     r_tx_valid    <= 1'b0;
                     r_pixel_index <= 10'd0;
                     r_state       <= S_FETCH;
                  end
               end
            end

            S_FETCH: begin
               r_tx_valid <= 1'b1;
               r_tx_data  <= pattern_byte;
               r_tx_dc    <= 1'b1;
               r_state    <= S_DATA;
            end

            S_DATA: begin
               if (tx_ready) begin
                  r_tx_valid <= 1'b0;
                  if (r_pixel_index == LP_LAST_PIX) begin
                     r_frame_done <= 1'b1;
                     r_wait_cnt   <= 32'd0;
                     r_busy       <= 1'b0;
                     r_state      <= S_WAIT;
                  end else begin
                     r_pixel_index <= r_pixel_index + 10'd1;
                     r_state       <= S_FETCH;
                  end
               end
            end

            S_WAIT: begin
               if (r_wait_cnt == LP_WAIT_TC) begin
                  r_wait_cnt <= 32'd0;
                  if (enable) begin
                     r_state <= S_CMD;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_wait_cnt <= r_wait_cnt + 32'd1;
               end
            end

            default: begin
               r_state    <= S_IDLE;
               r_tx_valid <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign pixel_index  = r_pixel_index;
   assign tx_valid     = r_tx_valid;
   assign tx_data      = r_tx_data;
   assign tx_dc        = r_tx_dc;
   assign frame_number = r_frame_number;
   assign frame_done   = r_frame_done;
   assign busy         = r_busy;

endmodule

// File: tb/tb_oled_link_scheduler.sv
// ---------------------------------------------------------------------------
// tb_oled_link_scheduler
//
// Main instance (1024-byte frames) is checked against a stream model: every
// accepted byte must be the next one of {queued commands, address window,
// pattern bytes 0..N-1}. A second small instance (4-byte frames) runs enough
// frames to exercise frame_number wrap and frame_clr collisions.
// ---------------------------------------------------------------------------
module tb_oled_link_scheduler;

   localparam int PB    = 1024;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n, enable, frame_clr, cmd_valid;
   logic [7:0] cmd_data;
   logic       cmd_ready;
   logic [9:0] pixel_index;
   logic [7:0] pattern_byte;
   logic       tx_valid, tx_dc, tx_ready;
   logic [7:0] tx_data, frame_number;
   logic       frame_done, busy;

   logic       rst_s_n, frame_clr_s, cmd_valid_s, tx_ready_s, enable_s;
   logic [7:0] cmd_data_s;
   logic       cmd_ready_s;
   logic [9:0] pixel_index_s;
   logic [7:0] pattern_byte_s;
   logic       tx_valid_s, tx_dc_s;
   logic [7:0] tx_data_s, frame_number_s;
   logic       frame_done_s, busy_s;

   int   n_tests = 0;
   int   n_fail  = 0;
   bit   stall_mode = 1'b0;
   bit   s_done = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [7:0] gen(input int i);
      return 8'((i * 37) ^ (i >> 3) ^ 8'h5A);
   endfunction

   assign pattern_byte   = gen(int'(pixel_index));
   assign pattern_byte_s = gen(int'(pixel_index_s));

   oled_link_scheduler #(.FRAME_WAIT(32'd10), .CMD_DEPTH(DEPTH), .PIXEL_BYTES(PB)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .frame_clr(frame_clr),
      .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
      .pixel_index(pixel_index), .pattern_byte(pattern_byte),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_dc(tx_dc), .tx_ready(tx_ready),
      .frame_number(frame_number), .frame_done(frame_done), .busy(busy)
   );

   oled_link_scheduler #(.FRAME_WAIT(32'd2), .CMD_DEPTH(2), .PIXEL_BYTES(4)) u_dut_s (
      .clk(clk), .rst_n(rst_s_n), .enable(enable_s), .frame_clr(frame_clr_s),
      .cmd_valid(cmd_valid_s), .cmd_data(cmd_data_s), .cmd_ready(cmd_ready_s),
      .pixel_index(pixel_index_s), .pattern_byte(pattern_byte_s),
      .tx_valid(tx_valid_s), .tx_data(tx_data_s), .tx_dc(tx_dc_s), .tx_ready(tx_ready_s),
      .frame_number(frame_number_s), .frame_done(frame_done_s), .busy(busy_s)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- stream reference model (main instance) ----------------
   logic [7:0] addr_tab [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
   logic [7:0] m_cmdq [$];
   int         m_phase = 0;      // 0: command/address preamble, 1: pixel data
   int         m_addr_idx = 0;
   int         m_pix = 0;
   int         m_frames = 0;
   bit         m_done_pend = 1'b0;
   bit         m_stall = 1'b0;
   logic [8:0] m_hold = '0;

   always @(negedge clk) begin
      logic [7:0] c;
      if (!rst_n) begin
         m_cmdq.delete();
         m_phase     = 0;
         m_addr_idx  = 0;
         m_pix       = 0;
         m_frames    = 0;
         m_done_pend = 1'b0;
         m_stall     = 1'b0;
      end else begin
         chk("frame_done", 32'(frame_done), 32'(m_done_pend));
         if (m_done_pend) begin
            chk("frame_number", 32'(frame_number), 32'(m_frames & 255));
            chk("pix_hold", 32'(pixel_index), 32'(PB - 1));
         end
         m_done_pend = 1'b0;

         if (m_stall) begin
            chk("stall_valid", 32'(tx_valid), 32'd1);
            chk("stall_byte", 32'({tx_dc, tx_data}), 32'(m_hold));
         end
         m_stall = tx_valid && !tx_ready;
         m_hold  = {tx_dc, tx_data};

         if (cmd_valid && m_phase == 1) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(m_cmdq.size() < DEPTH));
            if (m_cmdq.size() < DEPTH) m_cmdq.push_back(cmd_data);
         end

         if (tx_valid && tx_ready) begin
            chk("busy_tx", 32'(busy), 32'd1);
            if (m_phase == 0) begin
               if (m_addr_idx == 0 && m_cmdq.size() > 0) begin
                  c = m_cmdq.pop_front();
                  chk("cmd_byte", 32'({tx_dc, tx_data}), 32'({1'b0, c}));
               end else begin
                  chk("addr_byte", 32'({tx_dc, tx_data}), 32'({1'b0, addr_tab[m_addr_idx]}));
                  m_addr_idx++;
                  if (m_addr_idx == 6) begin
                     m_phase = 1;
                     m_pix   = 0;
                  end
               end
            end else begin
               chk("pix_index", 32'(pixel_index), 32'(m_pix));
               chk("data_byte", 32'({tx_dc, tx_data}), 32'({1'b1, gen(m_pix)}));
               m_pix++;
               if (m_pix == PB) begin
                  m_phase     = 0;
                  m_addr_idx  = 0;
                  m_frames++;
                  m_done_pend = 1'b1;
               end
            end
         end
      end
   end

   // ---------------- main instance stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      tx_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
   endtask

   task automatic wait_frames(input int target);
      for (int k = 0; k < 12000; k++) begin
         if (m_frames >= target) break;
         tick();
      end
      chk("wait_frames", 32'(m_frames >= target), 32'd1);
   endtask

   task automatic wait_pix(input int n);
      for (int k = 0; k < 12000; k++) begin
         if (m_phase == 1 && m_pix >= n) break;
         tick();
      end
      chk("wait_pix", 32'(m_phase == 1 && m_pix >= n), 32'd1);
   endtask

   task automatic push(input logic [7:0] b);
      cmd_valid = 1'b1;
      cmd_data  = b;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; frame_clr = 1'b0; cmd_valid = 1'b0;
      cmd_data = 8'h00; tx_ready = 1'b1;
      tick(); tick();
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_tx_dc", 32'(tx_dc), 32'd0);
      chk("rst_pix", 32'(pixel_index), 32'd0);
      chk("rst_fnum", 32'(frame_number), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      rst_n = 1'b1;

      // enable low: stays idle
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_valid", 32'(tx_valid), 32'd0);
      end

      // frame 1: plain frame, no commands
      enable = 1'b1;
      wait_frames(1);

      // frame 2: push three commands mid-frame; sent before frame 3 window
      wait_pix(100);
      push(8'hA7); push(8'h81); push(8'h20);
      cmd_valid = 1'b0;
      wait_frames(2);

      // frame 3 with random stalls: six back-to-back pushes, only four fit
      stall_mode = 1'b1;
      wait_pix(300);
      for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
      cmd_valid = 1'b0;
      wait_frames(3);
      wait_frames(4);

      // reset mid-frame at pixel 500
      for (int k = 0; k < 12000; k++) begin
         if (pixel_index == 10'd500) break;
         tick();
      end
      chk("wait_pix500", 32'(pixel_index), 32'd500);
      rst_n = 1'b0;
      #2;
      chk("arst_tx_valid", 32'(tx_valid), 32'd0);
      chk("arst_tx_data", 32'(tx_data), 32'd0);
      chk("arst_tx_dc", 32'(tx_dc), 32'd0);
      chk("arst_pix", 32'(pixel_index), 32'd0);
      chk("arst_fnum", 32'(frame_number), 32'd0);
      chk("arst_done", 32'(frame_done), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
      tick(); tick();
      rst_n = 1'b1;

      // fresh frame; enable dropped mid-frame must still complete it
      wait_pix(200);
      enable = 1'b0;
      wait_frames(1);
      for (int k = 0; k < 15; k++) tick();
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("post_busy", 32'(busy), 32'd0);
         chk("post_valid", 32'(tx_valid), 32'd0);
      end
      chk("post_fnum", 32'(frame_number), 32'd1);

      for (int k = 0; k < 20000; k++) begin
         if (s_done) break;
         tick();
      end
      chk("small_done", 32'(s_done), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // ---------------- small instance: frame counter wrap and clear ----------------
   initial begin
      logic [7:0] s_exp;
      bit         seen;
      s_exp = 8'h00;
      rst_s_n = 1'b0; enable_s = 1'b1; frame_clr_s = 1'b0; cmd_valid_s = 1'b0;
      cmd_data_s = 8'h00; tx_ready_s = 1'b1;
      @(negedge clk); @(negedge clk);
      rst_s_n = 1'b1;
      for (int f = 0; f < 290; f++) begin
         seen = 1'b0;
         if (f == 280) begin
            // clear asserted in the same cycle the last byte is accepted
            for (int k = 0; k < 200; k++) begin
               @(negedge clk);
               if (tx_valid_s && tx_dc_s && pixel_index_s == 10'd3) begin
                  seen = 1'b1;
                  break;
               end
            end
            chk("s_wait_last", 32'(seen), 32'd1);
            frame_clr_s = 1'b1;
            @(negedge clk);
            frame_clr_s = 1'b0;
            chk("s_clr_acc_done", 32'(frame_done_s), 32'd1);
            chk("s_clr_acc_fnum", 32'(frame_number_s), 32'd0);
            s_exp = 8'h00;
         end else begin
            for (int k = 0; k < 200; k++) begin
               @(negedge clk);
               if (frame_done_s) begin
                  seen = 1'b1;
                  break;
               end
            end
            chk("s_frame_done", 32'(seen), 32'd1);
            s_exp = s_exp + 8'd1;
            chk("s_fnum", 32'(frame_number_s), 32'(s_exp));
            if (f == 255) chk("s_wrap", 32'(frame_number_s), 32'd0);
            if (f == 260) begin
               // clear during the frame_done cycle
               frame_clr_s = 1'b1;
               @(negedge clk);
               frame_clr_s = 1'b0;
               chk("s_clr_done_fnum", 32'(frame_number_s), 32'd0);
               s_exp = 8'h00;
            end
         end
      end
      s_done = 1'b1;
   end

endmodule

// File: doc/oled_link_scheduler.md
OLED_LINK_SCHEDULER -- requirements
Module: oled_link_scheduler

Interface
REQ-001 Parameter FRAME_WAIT, default 32'd450000; idle cycles between end of one frame and start of the next.
REQ-002 Parameter CMD_DEPTH, default 4; runtime command FIFO depth (power of two, 2..16).
REQ-003 Parameter PIXEL_BYTES, default 1024; data bytes per frame (128x64 / 8).
REQ-004 clk  in  1  single system clock, all logic on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  high once display power-up/init sequence is complete.
REQ-007 frame_clr  in  1  single-cycle pulse; clears frame_number (game restart).
REQ-008 cmd_valid / cmd_data  in  1 / 8  runtime command push (contrast, invert, etc.).
REQ-009 cmd_ready  out  1  FIFO not full.
REQ-010 pixel_index  out  10  byte address presented to the pattern generator.
REQ-011 pattern_byte  in  8  generator output, valid exactly 1 cycle after pixel_index changes.
REQ-012 tx_valid / tx_data / tx_dc  out  1 / 8 / 1  byte to SPI serializer; tx_dc 0 = command, 1 = data.
REQ-013 tx_ready  in  1  serializer accepts byte when tx_valid and tx_ready both high.
REQ-014 frame_number  out  8  completed-frame count.
REQ-015 frame_done  out  1  single-cycle pulse on acceptance of last data byte.
REQ-016 busy  out  1  high in every state except IDLE and WAIT.

Function
REQ-017 States: IDLE, CMD, ADDR, FETCH, DATA, WAIT; one-hot or encoded, implementer's choice.
REQ-018 IDLE -> CMD when enable=1; otherwise stay.
REQ-019 CMD: pop and send FIFO entries (tx_dc=0) until empty, then -> ADDR; empty FIFO on entry -> ADDR next cycle.
REQ-020 ADDR: send fixed 6 bytes 8'h21,8'h00,8'h7F,8'h22,8'h00,8'h07 (tx_dc=0), in order, then pixel_index<=0, -> FETCH.
REQ-021 FETCH: one cycle; next cycle latch pattern_byte into tx_data, tx_dc=1, tx_valid=1, -> DATA.
REQ-022 DATA: on accept, if pixel_index==PIXEL_BYTES-1 -> WAIT with frame_done pulse; else pixel_index+1, -> FETCH.
REQ-023 WAIT: count FRAME_WAIT cycles from 0; at terminal count -> CMD if enable=1, else IDLE.
REQ-024 enable is sampled only in IDLE and at WAIT terminal count; deassertion mid-frame completes the frame.
REQ-025 tx_valid, tx_data, tx_dc held stable while tx_valid=1 and tx_ready=0; tx_valid never drops without acceptance.
REQ-026 Throughput: minimum 2 cycles per data byte (FETCH + accept); tx_ready held high gives 1 byte per 2 cycles.
REQ-027 FIFO push when cmd_valid & cmd_ready; push while full is ignored, contents unchanged.
REQ-028 Simultaneous push and pop permitted when not full; occupancy unchanged, order preserved.
REQ-029 Commands pushed during ADDR/DATA/WAIT wait for the next CMD state; never interleaved inside a frame.
REQ-030 frame_number increments by 1 on frame_done, wrapping 8'hFF -> 8'h00.
REQ-031 frame_clr sets frame_number to 0 next cycle; coincident with frame_done, clear wins (result 0).
REQ-032 pixel_index remains at PIXEL_BYTES-1 through WAIT and CMD; reloaded only in ADDR.

Reset
REQ-033 rst_n low: state=IDLE, FIFO empty, pixel_index=0, frame_number=0, tx_valid=0, tx_data=0, tx_dc=0, frame_done=0, busy=0, wait counter=0, cmd_ready=1.
REQ-034 Reset asserted mid-transfer aborts immediately; no partial frame resumes after release.

Verification
REQ-035 enable=1, tx_ready=1, FRAME_WAIT=10, empty FIFO -> 6 command bytes 21 00 7F 22 00 07 (dc=0), then 1024 dc=1 bytes matching pattern_byte for index 0..1023, one frame_done, frame_number=1.
REQ-036 Push 8'hA7, 8'h81, 8'h20 during DATA -> all three sent dc=0 in order after WAIT, before the next 8'h21.
REQ-037 CMD_DEPTH=4, push 6 commands back-to-back with no pop -> cmd_ready low after 4th, only first 4 sent.
REQ-038 tx_ready toggled randomly -> tx_data/tx_dc stable while stalled; byte sequence identical to REQ-035.
REQ-039 frame_number=8'hFF at frame_done -> 8'h00; frame_clr coincident with frame_done -> 8'h00.
REQ-040 rst_n pulsed low at pixel_index=500 -> all outputs at reset values; after release, next frame starts with 8'h21 and index 0.
